// File: rtl/note_tx_pkg.sv
// Shared definitions for the note frame transmitter.
//   tx_state_t        : frame FSM states
//   SYNC_BYTE_DEFAULT : default first byte of every frame
//   FRAME_LEN_BASE    : bytes per frame without the checksum byte
//   note_t            : queued note event (tone 8 bits + duration 16 bits)
// Optional feature macro: NOTE_TX_CHECKSUM_EN (adds the checksum helper).
package note_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStrobe,
    StWaitRise,
    StWaitFall
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_LEN_BASE = 4;

  typedef struct packed {
    logic [7:0]  tone;
    logic [15:0] dur;
  } note_t;

`ifdef NOTE_TX_CHECKSUM_EN
  function automatic logic [7:0] note_checksum(input note_t n);
    return n.tone ^ n.dur[15:8] ^ n.dur[7:0];
  endfunction
`endif

endpackage

// File: rtl/note_fifo.sv
// Synchronous first-word-fall-through FIFO for note events.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   push, wdata    : write request and data (ignored when full)
//   pop            : read request (ignored when empty); rdata shows the head entry
//   full, empty    : status flags
//   level          : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module note_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/note_frame_tx.sv
// Note frame transmitter: queues note events and sends each one to a UART
// transmitter as the byte frame SYNC_BYTE, tone, dur[15:8], dur[7:0]
// (plus a checksum byte tone ^ dur[15:8] ^ dur[7:0] when the macro
// NOTE_TX_CHECKSUM_EN is defined).
// Ports:
//   sys_clk, sys_rst         : clock, asynchronous active-high reset
//   note_valid/ready         : event handshake; note_ready is high when not full
//   note_tone, note_dur      : event payload
//   send_en, send_data       : one-cycle byte strobe and held byte to the UART
//   tx_busy                  : UART busy flag
//   fifo_level               : number of queued events
//   frame_done               : one-cycle pulse after the last byte of a frame
//   idle                     : FSM idle and FIFO empty
module note_frame_tx
  import note_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int unsigned RISE_TIMEOUT = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          note_valid,
  output logic                          note_ready,
  input  logic [7:0]                    note_tone,
  input  logic [15:0]                   note_dur,
  output logic                          send_en,
  output logic [7:0]                    send_data,
  input  logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done,
  output logic                          idle
);

`ifdef NOTE_TX_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_BASE + 1;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);
  localparam int unsigned CW = (RISE_TIMEOUT > 1) ? $clog2(RISE_TIMEOUT) : 1;
  localparam logic [CW-1:0] RISE_LAST = CW'(RISE_TIMEOUT - 1);

  tx_state_t     state;
  note_t         frame;
  note_t         fifo_rdata;
  note_t         fifo_wdata;
  logic [2:0]    byte_idx;
  logic [CW-1:0] rise_cnt;
  logic [7:0]    cur_byte;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;

  assign fifo_wdata = '{tone: note_tone, dur: note_dur};
  assign note_ready = !fifo_full;
  assign fifo_push  = note_valid && note_ready;
  // The frame register is loaded on the same edge the head entry is popped.
  assign fifo_pop   = (state == StIdle) && !fifo_empty;
  assign idle       = (state == StIdle) && fifo_empty;

  note_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(note_t))
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx)
      3'd1:    cur_byte = frame.tone;
      3'd2:    cur_byte = frame.dur[15:8];
      3'd3:    cur_byte = frame.dur[7:0];
`ifdef NOTE_TX_CHECKSUM_EN
      3'd4:    cur_byte = note_checksum(frame);
`endif
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= StIdle;
      frame      <= '0;
      byte_idx   <= '0;
      rise_cnt   <= '0;
      send_en    <= 1'b0;
      send_data  <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      send_en    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        StIdle: begin
          if (!fifo_empty) begin
            frame    <= fifo_rdata;
            byte_idx <= '0;
            state    <= StLoad;
          end
        end
        StLoad: begin
          send_data <= cur_byte;
          state     <= StStrobe;
        end
        StStrobe: begin
          // A transmitter still busy from elsewhere holds the strobe back.
          if (!tx_busy) begin
            send_en  <= 1'b1;
            rise_cnt <= '0;
            state    <= StWaitRise;
          end
        end
        StWaitRise: begin
          // Give up waiting for busy after RISE_TIMEOUT cycles.
          if (tx_busy || (rise_cnt == RISE_LAST)) begin
            state <= StWaitFall;
          end else begin
            rise_cnt <= rise_cnt + 1'b1;
          end
        end
        StWaitFall: begin
          if (!tx_busy) begin
            if (byte_idx == LAST_IDX) begin
              byte_idx   <= '0;
              frame_done <= 1'b1;
              state      <= StIdle;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= StLoad;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_note_frame_tx.sv
// Directed self-checking bench for note_frame_tx with a simple UART model.
// Honours NOTE_TX_CHECKSUM_EN for the expected frame length and fifth byte.
module tb_note_frame_tx;

`ifdef NOTE_TX_CHECKSUM_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        note_valid = 1'b0;
  logic        note_ready;
  logic [7:0]  note_tone = 8'h00;
  logic [15:0] note_dur = 16'h0000;
  logic        send_en;
  logic [7:0]  send_data;
  logic        tx_busy = 1'b0;
  logic [2:0]  fifo_level;
  logic        frame_done;
  logic        idle;

  note_frame_tx #(
    .FIFO_DEPTH   (4),
    .SYNC_BYTE    (8'hA5),
    .RISE_TIMEOUT (4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_tone  (note_tone),
    .note_dur   (note_dur),
    .send_en    (send_en),
    .send_data  (send_data),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level),
    .frame_done (frame_done),
    .idle       (idle)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // UART model. Mode 0: busy rises 2 cycles after the strobe, stays 10 cycles.
  // Mode 1: busy always low. Mode 2: busy follows force_busy.
  int   busy_mode = 0;
  logic force_busy = 1'b0;
  int   pend = 0;
  int   hold = 0;
  always @(posedge sys_clk) begin
    if (busy_mode == 1) tx_busy <= 1'b0;
    else if (busy_mode == 2) tx_busy <= force_busy;
    else if (send_en) pend <= 1;
    else if (pend != 0) begin
      pend    <= 0;
      tx_busy <= 1'b1;
      hold    <= 10;
    end else if (hold != 0) begin
      hold <= hold - 1;
      if (hold == 1) tx_busy <= 1'b0;
    end
  end

  // Monitor: strobed bytes with cycle stamps, frame_done pulses, busy falls.
  logic [7:0] got_bytes[$];
  int         got_t[$];
  int         fd_cnt = 0;
  int         fd_t = 0;
  int         viol = 0;
  int         fall_t = -1;
  logic       busy_prev = 1'b0;
  always @(negedge sys_clk) begin
    if (send_en) begin
      got_bytes.push_back(send_data);
      got_t.push_back(cyc);
    end
    if (send_en && tx_busy) viol++;
    if (frame_done) begin
      fd_cnt++;
      fd_t = cyc;
    end
    if (busy_prev && !tx_busy) fall_t = cyc;
    busy_prev = tx_busy;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  function automatic logic [7:0] qb(input int i);
    if (i < got_bytes.size()) return got_bytes[i];
    return 8'hxx;
  endfunction

  function automatic int qt(input int i);
    if (i < got_t.size()) return got_t[i];
    return -1000;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [7:0] t, input logic [15:0] d, input int k);
    case (k)
      0:       return 8'hA5;
      1:       return t;
      2:       return d[15:8];
      3:       return d[7:0];
      default: return t ^ d[15:8] ^ d[7:0];
    endcase
  endfunction

  task automatic check_frame(input int base, input logic [7:0] t, input logic [15:0] d,
                             input string tag);
    for (int k = 0; k < FLEN; k++) begin
      check($sformatf("%s_byte%0d", tag, k), 32'(qb(base + k)), 32'(exp_byte(t, d, k)));
    end
  endtask

  task automatic push(input logic [7:0] t, input logic [15:0] d);
    int g = 0;
    while (!note_ready && g < 1000) begin
      tick();
      g++;
    end
    if (g >= 1000) check("push_ready_timeout", 32'(note_ready), 1);
    note_valid = 1'b1;
    note_tone  = t;
    note_dur   = d;
    tick();
    note_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int g = 0;
    while (fd_cnt < target && g < budget) begin
      tick();
      g++;
    end
    check(tag, fd_cnt, target);
  endtask

  task automatic wait_bytes(input int target, input int budget, input string tag);
    int g = 0;
    while (got_bytes.size() < target && g < budget) begin
      tick();
      g++;
    end
    check(tag, got_bytes.size(), target);
  endtask

  logic [7:0]  c_tone[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [15:0] c_dur[5]  = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A};

  initial begin
    int base;
    int fdb;
    int t0;

    // Reset state
    sys_rst = 1'b1;
    repeat (3) tick();
    check("rst_send_en", 32'(send_en), 0);
    check("rst_send_data", 32'(send_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_note_ready", 32'(note_ready), 1);
    check("rst_idle", 32'(idle), 1);
    check("rst_fifo_level", 32'(fifo_level), 0);
    sys_rst = 1'b0;
    tick();

    // Single event through the busy-handshake UART model
    base = got_bytes.size();
    push(8'h12, 16'h01F4);
    wait_frames(1, 400, "A_frame_done");
    tick();
    tick();
    check("A_byte_count", got_bytes.size() - base, FLEN);
    check_frame(base, 8'h12, 16'h01F4, "A");
    check("A_strobe_gap", qt(base + 1) - qt(base), 15);
    check("A_single_done", fd_cnt, 1);
    check("A_idle", 32'(idle), 1);

    // Five back-to-back events into a depth-4 FIFO
    base = got_bytes.size();
    fdb  = fd_cnt;
    for (int i = 0; i < 5; i++) push(c_tone[i], c_dur[i]);
    check("C_ready_low", 32'(note_ready), 0);
    check("C_level_full", 32'(fifo_level), 4);
    wait_frames(fdb + 5, 2000, "C_frames_done");
    tick();
    tick();
    check("C_byte_count", got_bytes.size() - base, 5 * FLEN);
    for (int i = 0; i < 5; i++) check_frame(base + i * FLEN, c_tone[i], c_dur[i], "C");
    check("C_level_empty", 32'(fifo_level), 0);
    check("C_idle", 32'(idle), 1);

    // Reset during the third byte of a frame
    base = got_bytes.size();
    fdb  = fd_cnt;
    push(8'hAB, 16'hCDEF);
    wait_bytes(base + 3, 400, "D_third_strobe");
    tick();
    sys_rst = 1'b1;
    tick();
    check("D_rst_send_en", 32'(send_en), 0);
    check("D_rst_send_data", 32'(send_data), 0);
    tick();
    sys_rst = 1'b0;
    tick();
    check("D_idle", 32'(idle), 1);
    check("D_level", 32'(fifo_level), 0);
    repeat (60) tick();
    check("D_no_strobe", got_bytes.size() - base, 3);
    check("D_no_done", fd_cnt, fdb);
    base = got_bytes.size();
    push(8'h5A, 16'h0102);
    wait_frames(fdb + 1, 400, "D_new_frame_done");
    tick();
    check_frame(base, 8'h5A, 16'h0102, "D");

    // Busy never rises: every byte advances on the rise timeout
    busy_mode = 1;
    repeat (3) tick();
    base = got_bytes.size();
    fdb  = fd_cnt;
    push(8'h34, 16'h5678);
    wait_frames(fdb + 1, 200, "B_frame_done");
    tick();
    check_frame(base, 8'h34, 16'h5678, "B");
    for (int k = 0; k < FLEN - 1; k++) begin
      check($sformatf("B_gap%0d", k), qt(base + k + 1) - qt(base + k), 7);
    end
    t0 = qt(base);
    check("B_frame_span", fd_t - t0, (FLEN - 1) * 7 + 5);

    // Busy already high before the event arrives
    force_busy = 1'b1;
    busy_mode  = 2;
    repeat (3) tick();
    base = got_bytes.size();
    fdb  = fd_cnt;
    push(8'h77, 16'h8899);
    repeat (20) tick();
    check("E_held_no_strobe", got_bytes.size() - base, 0);
    check("E_not_idle", 32'(idle), 0);
    check("E_level_popped", 32'(fifo_level), 0);
    force_busy = 1'b0;
    wait_bytes(base + 1, 50, "E_first_strobe");
    check("E_gap_after_fall", 32'((qt(base) - fall_t) >= 1), 1);
    wait_frames(fdb + 1, 200, "E_frame_done");
    tick();
    check_frame(base, 8'h77, 16'h8899, "E");
    check("E_no_strobe_while_busy", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
